fread_responder: RTL and testbench
==================================

Name: fread_responder

Overview:
- Serves the server end of the "fread" request/response stream.
- Accepts a request carrying a 32-bit byte offset and streams CHUNK_LEN bytes from a local 16-bit-wide word memory.
- Emits resp_data/resp_valid for the consumer and pulses pw_end when a chunk completes.
- Used as an on-FPGA stand-in for the ESP file source, for loopback and bring-up of loaders.

Parameters:
- CHUNK_LEN, 2048: bytes returned per request (0x800); range 1..65535.
- MEM_WORDS, 6144: depth of the backing word memory; valid byte range is 0..2*MEM_WORDS-1.
- AW, 13: width of mem_addr; must satisfy 2^AW >= MEM_WORDS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_offset  in  32  byte offset of the first byte; sampled on the handshake
- resp_data  out  8  response byte
- resp_valid  out  1  resp_data valid
- resp_ready  in  1  consumer takes the byte; tie high for consumers without backpressure
- pw_end  out  1  one-cycle pulse after the last byte of a chunk is transferred
- busy  out  1  chunk in progress
- oob  out  1  sticky flag: a byte outside the memory range was served; cleared on the next request handshake
- mem_addr  out  AW  word address to the backing memory
- mem_rdata  in  16  word data, registered, valid 1 cycle after mem_addr; low byte = even offset

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values:
  - req_ready=0, resp_valid=0, resp_data=0, pw_end=0, busy=0, oob=0, mem_addr=0.
  - Next state IDLE.
  - Reset mid-chunk aborts immediately with no pw_end.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch offset into byte pointer ptr, load remaining count rem=CHUNK_LEN, clear oob, go to FETCH.
  - req_ready drops the cycle after the handshake.
- FETCH: drive mem_addr=ptr[AW:1]; go to WAIT.
- WAIT: go to SEND.
- SEND entry: capture mem_rdata into a 16-bit word register; resp_valid=1; resp_data = ptr[0] ? high byte : low byte.
- Out-of-range bytes:
  - A byte is out of range if ptr >= 2*MEM_WORDS, compared on the full 32 bits.
  - Its resp_data is 0xFF and oob is set.
  - No memory read is required for it, but the FSM timing is unchanged.
- SEND transfer (resp_valid&resp_ready): ptr+=1, rem-=1.
  - If rem was 1: drop resp_valid, go to DONE.
  - Else if the new ptr is odd (same word): present the high byte of the held word next cycle; no refetch.
  - Else: drop resp_valid, go to FETCH.
- Throughput and latency:
  - Sustained throughput: 2 bytes per 4 cycles with resp_ready=1.
  - First byte valid 3 cycles after the handshake cycle.
- resp_ready=0 holds resp_data/resp_valid stable; there is no timeout.
- DONE: pw_end=1 for exactly one cycle; go to IDLE (req_ready=1 next cycle).
- busy=1 in every state except IDLE.
- Odd start offset: the first byte is the high byte of word offset>>1.
- Pointer arithmetic is 32-bit and wraps 0xFFFFFFFF→0. Wrapped bytes are range-checked normally, so wrap re-enters the valid range at 0.
- req_valid asserted outside IDLE is ignored; the request is held by the requester until accepted.

Optional Feature:
- FREAD_RESP_CSUM_EN defined:
  - Adds output csum[15:0]: the 16-bit wrapping sum of all bytes transferred in the current chunk.
  - Cleared on request handshake; updated on each resp transfer; stable from the pw_end cycle until the next handshake.
  - Reset value 0.
- Undefined: no csum port, no adder logic.

Test Plan:
- Memory word i = i (16-bit); request offset 0, CHUNK_LEN=8, resp_ready=1 → bytes 00,00,01,00,02,00,03,00; first resp_valid 3 cycles after handshake; pw_end 1 cycle after the 8th transfer; oob=0.
- Offset 0x0003, CHUNK_LEN=4 → bytes 00(high of word1),02,00,03,00 truncated to 00,02,00,03; only 3 fetches issued.
- Offset 2*MEM_WORDS-2 = 0x2FFE, CHUNK_LEN=4 → 0xFF,0x17,0xFF,0xFF (word 0x17FF=0x17FF gives FF,17); oob=1 after the 3rd byte.
- resp_ready toggled 1,0,0,1 per cycle during SEND → resp_data stable while stalled; byte order and count unchanged; no dropped or duplicated bytes.
- rst_n=0 for 1 cycle mid-chunk (after 3 bytes) → all outputs at reset values next cycle; no pw_end; new request at 0 returns the full chunk from byte 0.
- With FREAD_RESP_CSUM_EN, offset 0, CHUNK_LEN=8 → csum=0x0006 at pw_end; cleared to 0 on the next handshake.

Source files
------------

// File: rtl/fread_responder_if.sv
// rtl/fread_responder_if.sv - request/response stream bundle for the fread responder
interface fread_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;

  modport master (
    output req_valid, req_offset, resp_ready,
    input  req_ready, resp_data, resp_valid
  );

  modport slave (
    input  req_valid, req_offset, resp_ready,
    output req_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/fread_responder.sv
// rtl/fread_responder.sv - streams CHUNK_LEN bytes from a 16-bit word memory per offset request
// Optional chunk checksum output csum enabled by FREAD_RESP_CSUM_EN.
module fread_responder #(
  parameter int CHUNK_LEN = 2048,
  parameter int MEM_WORDS = 6144,
  parameter int AW        = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  fread_responder_if.slave bus,
  output logic          pw_end,
  output logic          busy,
  output logic          oob,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata
`ifdef FREAD_RESP_CSUM_EN
  ,
  output logic [15:0]   csum
`endif
);

  localparam logic [31:0] BYTE_LIMIT = 32'(2 * MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [31:0]   ptr;
  logic [15:0]   rem;
  logic [15:0]   word;
  logic [7:0]    resp_data_q;
  logic [AW-1:0] mem_addr_q;
  logic          req_ready_q;
  logic          oob_q;
  logic          cur_oob;
  logic          accept;
  logic          xfer;
  logic [31:0]   ptr_inc;
  logic [31:0]   fetch_ptr;

  // Out-of-range bytes read as 0xFF regardless of what the memory returned.
  function automatic logic [7:0] pick(input logic [31:0] p, input logic [15:0] w);
    if (p >= BYTE_LIMIT) return 8'hFF;
    return p[0] ? w[15:8] : w[7:0];
  endfunction

  assign ptr_inc   = ptr + 32'd1;
  assign fetch_ptr = accept ? bus.req_offset : ptr_inc;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_SEND;
      S_SEND: begin
        if (bus.resp_ready) begin
          xfer = 1'b1;
          if (rem == 16'd1)     state_next = S_DONE;
          else if (ptr_inc[0]) state_next = S_SEND;
          else                 state_next = S_FETCH;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= 32'd0;
      rem         <= 16'd0;
      word        <= 16'd0;
      resp_data_q <= 8'd0;
      mem_addr_q  <= '0;
      req_ready_q <= 1'b0;
      oob_q       <= 1'b0;
      cur_oob     <= 1'b0;
    end else begin
      state       <= state_next;
      req_ready_q <= (state_next == S_IDLE);
      if (state_next == S_FETCH) mem_addr_q <= fetch_ptr[AW:1];
      if (accept) begin
        ptr   <= bus.req_offset;
        rem   <= 16'(CHUNK_LEN);
        oob_q <= 1'b0;
      end
      if (state == S_WAIT) begin
        word        <= mem_rdata;
        resp_data_q <= pick(ptr, mem_rdata);
        cur_oob     <= (ptr >= BYTE_LIMIT);
      end
      if (xfer) begin
        ptr <= ptr_inc;
        rem <= rem - 16'd1;
        if (cur_oob) oob_q <= 1'b1;
        // High byte of the word already held; no refetch needed.
        if (state_next == S_SEND) begin
          resp_data_q <= pick(ptr_inc, word);
          cur_oob     <= (ptr_inc >= BYTE_LIMIT);
        end
      end
    end
  end

`ifdef FREAD_RESP_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst_n)    csum_q <= 16'd0;
    else if (accept) csum_q <= 16'd0;
    else if (xfer)   csum_q <= csum_q + {8'd0, resp_data_q};
  end

  assign csum = csum_q;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = (state == S_SEND);
  assign bus.resp_data  = resp_data_q;
  assign pw_end         = (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign oob            = oob_q;
  assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_fread_responder.sv
// tb/tb_fread_responder.sv - randomized self-checking bench for fread_responder
module tb_fread_responder;
  localparam int CHUNK = 8;
  localparam int MW    = 6144;
  localparam int AW    = 13;
  localparam logic [31:0] LIMIT = 32'(2 * MW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fread_responder_if bus();
  logic          pw_end, busy, oob;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
`ifdef FREAD_RESP_CSUM_EN
  logic [15:0]   csum;
`endif

  fread_responder #(.CHUNK_LEN(CHUNK), .MEM_WORDS(MW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .pw_end    (pw_end),
    .busy      (busy),
    .oob       (oob),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
`ifdef FREAD_RESP_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  logic [15:0] mem [MW];
  always_ff @(posedge clk)
    mem_rdata <= (int'(mem_addr) < MW) ? mem[mem_addr] : 16'hDEAD;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] p);
    logic [15:0] w;
    if (p >= LIMIT) return 8'hFF;
    w = mem[int'(p >> 1)];
    return p[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_data"}, bus.resp_data, 0);
    chk({tag, "_pw_end"}, pw_end, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_oob"}, oob, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
`ifdef FREAD_RESP_CSUM_EN
    chk({tag, "_csum"}, csum, 0);
`endif
  endtask

  // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random; abort_after>0 resets after that many bytes
  task automatic run_req(input logic [31:0] off, input int mode, input int abort_after, input bit chk_lat);
    logic [7:0]  exp_q[$];
    bit          exp_oob = 0;
    logic [15:0] exp_sum = 0;
    int          exp_fetch = 0;
    logic [31:0] p = off;
    int n = 0, cyc = 0, got = 0, first = -1, last_x = -1, fetch = 0;
    bit prev_v = 0, stalled = 0, done = 0;
    logic [7:0] held = 0;
    logic [3:0] pat = 4'b1001;

    for (int i = 0; i < CHUNK; i++) begin
      exp_q.push_back(ref_byte(p));
      if (p >= LIMIT) exp_oob = 1;
      exp_sum += {8'd0, ref_byte(p)};
      if (i == 0 || !p[0]) exp_fetch++;
      p = p + 32'd1;
    end

    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_offset = off;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_offset = $urandom;

    while (!done && cyc < 400) begin
      case (mode)
        0:       bus.resp_ready = 1'b1;
        1:       bus.resp_ready = pat[3 - (cyc % 4)];
        default: bus.resp_ready = 1'($urandom % 2);
      endcase
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("req_ready_drop", bus.req_ready, 0);
        chk("busy_active", busy, 1);
`ifdef FREAD_RESP_CSUM_EN
        chk("csum_cleared", csum, 0);
`endif
      end
      if (stalled) chk("stall_hold", {23'd0, bus.resp_valid, bus.resp_data}, {23'd0, 1'b1, held});
      if (bus.resp_valid && !prev_v) begin
        fetch++;
        if (first < 0) first = cyc;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (got < CHUNK) chk("data", bus.resp_data, exp_q[got]);
        else chk("extra_byte", got, CHUNK - 1);
        got++;
        last_x = cyc;
        if (got == abort_after) begin
          @(posedge clk);
          #1 rst_n = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check_reset_outputs("abort");
          rst_n = 1'b1;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_pw_end", pw_end, 0);
          end
          return;
        end
      end
      stalled = bus.resp_valid && !bus.resp_ready;
      held    = bus.resp_data;
      prev_v  = bus.resp_valid;
      if (pw_end) begin
        done = 1;
        chk("pw_end_timing", cyc, last_x + 1);
        chk("byte_count", got, CHUNK);
        chk("oob_flag", oob, exp_oob);
        chk("fetch_count", fetch, exp_fetch);
`ifdef FREAD_RESP_CSUM_EN
        chk("csum", csum, exp_sum);
`endif
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk("pw_end_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("pw_end_single", pw_end, 0);
    chk("busy_idle", busy, 0);
    chk("req_ready_back", bus.req_ready, 1);
    if (chk_lat) chk("first_latency", first, 3);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 16'(i);
    bus.req_valid  = 1'b0;
    bus.req_offset = 32'd0;
    bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_req(32'd0, 0, 0, 1);
    run_req(32'd3, 0, 0, 1);
    run_req(32'h2FFE, 0, 0, 1);
    run_req(32'd0, 1, 0, 0);
    run_req(32'h2FFE, 0, 3, 0);
    run_req(32'd0, 0, 0, 1);
    run_req(32'hFFFF_FFFC, 0, 0, 1);

    for (int i = 0; i < MW; i++) mem[i] = 16'($urandom);
    for (int t = 0; t < 24; t++) begin
      logic [31:0] off;
      if (t % 5 == 4) off = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else            off = 32'($urandom_range(0, 2 * MW + 20));
      run_req(off, 2, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
